// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter that multiplexes NUM_SRC byte-stream requesters onto one
// UDP payload stream. It latches the destination IP and port at grant time,
// truncates packets at MAX_PKT_BYTES, and aborts grants whose source stalls.
module udp_tx_arbiter #(
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned MAX_PKT_BYTES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_SRC*8-1:0]    i_src_tdata,
  input  logic [NUM_SRC-1:0]      i_src_tvalid,
  input  logic [NUM_SRC-1:0]      i_src_tlast,
  output logic [NUM_SRC-1:0]      o_src_tready,
  input  logic [NUM_SRC*32-1:0]   i_src_ip,
  input  logic [NUM_SRC*16-1:0]   i_src_port,
  output logic [7:0]              o_tx_tdata,
  output logic                    o_tx_tvalid,
  output logic                    o_tx_tlast,
  input  logic                    i_tx_tready,
  output logic [31:0]             o_tx_ip,
  output logic [15:0]             o_tx_port,
  output logic [NUM_SRC-1:0]      o_grant,
  output logic                    o_busy,
  output logic [15:0]             o_timeout_cnt
);

  localparam int unsigned GW = $clog2(NUM_SRC);
  localparam int unsigned BW = $clog2(MAX_PKT_BYTES + 1);
  localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, XFER, ABORT, DRAIN} state_t;

  state_t             state;
  logic [GW-1:0]      grant_idx;
  logic [GW-1:0]      last_grant;
  logic [NUM_SRC-1:0] grant_oh;
  logic [BW-1:0]      byte_cnt;
  logic [SW-1:0]      stall_cnt;

  logic [7:0]         sel_tdata;
  logic               sel_tvalid;
  logic               sel_tlast;
  logic               at_max;

  logic               arb_any;
  logic [GW-1:0]      arb_idx;
  logic [GW:0]        cand;
  logic [31:0]        arb_ip;
  logic [15:0]        arb_port;

  // Select the granted source's stream signals.
  always_comb begin
    sel_tdata  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (GW'(k) == grant_idx) begin
        sel_tdata  = i_src_tdata[k*8 +: 8];
        sel_tvalid = i_src_tvalid[k];
        sel_tlast  = i_src_tlast[k];
      end
    end
  end

  // Byte about to be forwarded is the last one allowed in this grant.
  assign at_max = (byte_cnt == BW'(MAX_PKT_BYTES - 1));

  // Round-robin search: offsets 1..NUM_SRC from last_grant, so the previous
  // winner is considered last and cannot win back-to-back against a rival.
  always_comb begin
    arb_any = 1'b0;
    arb_idx = last_grant;
    cand    = '0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      cand = {1'b0, last_grant} + (GW+1)'(off);
      if (cand >= (GW+1)'(NUM_SRC))
        cand = cand - (GW+1)'(NUM_SRC);
      if (!arb_any && i_src_tvalid[GW'(cand)]) begin
        arb_any = 1'b1;
        arb_idx = GW'(cand);
      end
    end
  end

  // Header fields of the arbitration winner.
  always_comb begin
    arb_ip   = '0;
    arb_port = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (GW'(k) == arb_idx) begin
        arb_ip   = i_src_ip[k*32 +: 32];
        arb_port = i_src_port[k*16 +: 16];
      end
    end
  end

  // Stream outputs per state; forced quiet while reset is held so an
  // in-flight packet is dropped without a trailing beat.
  always_comb begin
    o_tx_tdata   = '0;
    o_tx_tvalid  = 1'b0;
    o_tx_tlast   = 1'b0;
    o_src_tready = '0;
    if (!i_rst) begin
      case (state)
        XFER: begin
          o_tx_tdata   = sel_tdata;
          o_tx_tvalid  = sel_tvalid;
          o_tx_tlast   = sel_tlast || at_max;
          o_src_tready = i_tx_tready ? grant_oh : '0;
        end
        ABORT: begin
          o_tx_tvalid = 1'b1;
          o_tx_tlast  = 1'b1;
        end
        DRAIN: begin
          o_src_tready = grant_oh;
        end
        default: ;
      endcase
    end
  end

  assign o_grant = grant_oh;
  assign o_busy  = (state != IDLE);

  // Arbitration / transfer state machine with registered grant, header and
  // counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      grant_idx     <= '0;
      last_grant    <= GW'(NUM_SRC - 1);
      grant_oh      <= '0;
      byte_cnt      <= '0;
      stall_cnt     <= '0;
      o_tx_ip       <= '0;
      o_tx_port     <= '0;
      o_timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_idx <= arb_idx;
            grant_oh  <= NUM_SRC'(1) << arb_idx;
            o_tx_ip   <= arb_ip;
            o_tx_port <= arb_port;
            byte_cnt  <= '0;
            stall_cnt <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (sel_tvalid) begin
            stall_cnt <= '0;
            if (i_tx_tready) begin
              byte_cnt <= byte_cnt + 1'b1;
              if (sel_tlast) begin
                state      <= IDLE;
                last_grant <= grant_idx;
                grant_oh   <= '0;
              end else if (at_max) begin
                state <= DRAIN;
              end
            end
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == SW'(TIMEOUT_CYCLES - 1)) begin
              state <= ABORT;
              if (o_timeout_cnt != '1)
                o_timeout_cnt <= o_timeout_cnt + 1'b1;
            end
          end
        end
        ABORT: begin
          if (i_tx_tready)
            state <= DRAIN;
        end
        DRAIN: begin
          if (sel_tvalid && sel_tlast) begin
            state      <= IDLE;
            last_grant <= grant_idx;
            grant_oh   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2 (legal range 2..4): number of transmit requesters.
REQ-002 SHALL have parameter MAX_PKT_BYTES, default 64: maximum number of payload bytes forwarded per grant.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of consecutive stall cycles before a grant is aborted.
REQ-004 SHALL have port i_clk, input, width 1: clock; reset i_rst, synchronous, active-high; clock i_clk.
REQ-005 SHALL have port i_rst, input, width 1: synchronous active-high reset.
REQ-006 SHALL have port i_src_tdata, input, width NUM_SRC*8: payload byte per source; source k occupies bits [8k+7:8k].
REQ-007 SHALL have ports i_src_tvalid and i_src_tlast, input, width NUM_SRC each: per-source valid and last.
REQ-008 SHALL have port o_src_tready, output, width NUM_SRC: per-source ready.
REQ-009 SHALL have port i_src_ip, input, width NUM_SRC*32: per-source destination IP.
REQ-010 SHALL have port i_src_port, input, width NUM_SRC*16: per-source destination port.
REQ-011 SHALL have ports o_tx_tdata (8), o_tx_tvalid (1) and o_tx_tlast (1), all outputs: the shared UDP payload stream.
REQ-012 SHALL have port i_tx_tready, input, width 1: ready from the UDP stack.
REQ-013 SHALL have ports o_tx_ip (32) and o_tx_port (16), outputs: header fields latched for the current packet.
REQ-014 SHALL have ports o_grant (NUM_SRC, one-hot or zero), o_busy (1) and o_timeout_cnt (16), all outputs: status.

Function
REQ-015 SHALL implement states IDLE, XFER, ABORT and DRAIN.
REQ-016 SHALL, in IDLE with any i_src_tvalid high, grant exactly one source by round-robin starting at (last_grant+1) mod NUM_SRC.
REQ-017 SHALL, on granting, register o_grant, latch o_tx_ip and o_tx_port from the granted source, clear the byte and stall counters, and enter XFER on the next cycle (1-cycle arbitration latency).
REQ-018 SHALL, in XFER, drive o_tx_tdata, o_tx_tvalid and o_tx_tlast combinationally from the granted source, and drive o_src_tready[grant] = i_tx_tready with all other tready bits 0.
REQ-019 SHALL count a beat on each o_tx_tvalid&&i_tx_tready handshake; a beat with source tlast SHALL return the block to IDLE and update last_grant.
REQ-020 SHALL, on the beat where the byte count reaches MAX_PKT_BYTES without source tlast, force o_tx_tlast=1 on that beat and enter DRAIN.
REQ-021 SHALL increment the stall counter in XFER on each cycle the granted tvalid is low, and clear it on each cycle that tvalid is high.
REQ-022 SHALL enter ABORT when the stall counter reaches TIMEOUT_CYCLES, and increment o_timeout_cnt, saturating at 0xFFFF.
REQ-023 SHALL, in ABORT, drive o_tx_tvalid=1, o_tx_tlast=1 and o_tx_tdata=0x00 with o_src_tready all 0, holding until i_tx_tready, then enter DRAIN.
REQ-024 SHALL, in DRAIN, drive o_src_tready[grant]=1 with o_tx_tvalid=0, discarding bytes until a source tlast beat, then enter IDLE and update last_grant.
REQ-025 SHALL, in IDLE, drive o_tx_tvalid=0, o_tx_tlast=0, o_tx_tdata=0 and o_src_tready=0 (no beat is accepted in the arbitration cycle).
REQ-026 SHALL drive o_busy=1 in every state except IDLE.
REQ-027 SHALL hold o_tx_ip and o_tx_port stable from grant until the next grant, ignoring source changes mid-packet.
REQ-028 SHALL NOT re-grant the same source back-to-back when another source is valid in IDLE.
REQ-029 SHALL, for a single-byte packet (tlast on the first beat), forward exactly one beat and return to IDLE.

Reset
REQ-030 SHALL, on i_rst, set the state to IDLE, o_grant=0, o_busy=0, o_tx_tvalid=0, o_tx_tlast=0, o_tx_tdata=0, o_src_tready=0, o_tx_ip=0, o_tx_port=0, o_timeout_cnt=0, and last_grant=NUM_SRC-1 (source 0 wins first).
REQ-031 SHALL, when reset is asserted mid-packet, abandon the packet immediately with no forced tlast, and SHALL take precedence over all other events.

Verification
REQ-032 SHALL cover: src0 and src1 both valid after reset, 4-byte packets 0x11..0x14 and 0x21..0x24 -> src0 packet first then src1, o_tx_ip/o_tx_port matching each source, 1 idle cycle between packets.
REQ-033 SHALL cover: i_tx_tready toggled every other cycle during a 4-byte packet -> bytes in order, no duplication or loss, tlast only on byte 4.
REQ-034 SHALL cover: src0 sends a 70-byte packet with MAX_PKT_BYTES=64 -> output tlast on byte 64, bytes 65..70 drained (src0 tready high, o_tx_tvalid 0), then IDLE.
REQ-035 SHALL cover: granted source stops after byte 2 with TIMEOUT_CYCLES=16 -> after 16 stall cycles one 0x00 beat with tlast, o_timeout_cnt=1, state DRAIN until source tlast.
REQ-036 SHALL cover: i_rst asserted on byte 3 of 8 -> next cycle o_tx_tvalid=0 and o_grant=0; after release src0 wins arbitration again.
